// File: rtl/usb_pkg.sv
// Shared USB definitions: the scheduler state encoding and the payload width
// that usb_state_machine also uses.
package usb_pkg;

  localparam int USB_PAYLOAD_W = 528;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    START    = 3'd2,
    WAIT_STP = 3'd3,
    BACKOFF  = 3'd4
  } tx_sched_state_t;

endpackage

// File: rtl/usb_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after
// ptr, wrapping. The caller owns the pointer register.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  int   best_s;
  int   pos_s;
  logic take_s;

  // Scan every source; its rotated distance from ptr is its priority.
  always_comb begin
    gnt    = '0;
    idx    = '0;
    best_s = N;
    pos_s  = 0;
    take_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      pos_s  = (i >= int'(ptr)) ? (i - int'(ptr)) : (i - int'(ptr) + N);
      take_s = req[i] && (pos_s < best_s);
      best_s = take_s ? pos_s : best_s;
      gnt    = take_s ? (ONE << i) : gnt;
      idx    = take_s ? IW'(i) : idx;
    end
  end

endmodule

// File: rtl/usb_tx_scheduler.sv
// Shares the ULPI transmit path between NUM_REQ packet sources: round-robin
// grant, payload latch, start pulse, completion/abort tracking and retries.
module usb_tx_scheduler
  import usb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int PAYLOAD_W      = USB_PAYLOAD_W,
  parameter int TIMEOUT_CYCLES = 2048,
  parameter int MAX_RETRY      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] payload,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           done,
  output logic [NUM_REQ-1:0]           err,
  input  logic                         dir,
  input  logic                         stp,
  output logic                         shift_out,
  output logic [PAYLOAD_W-1:0]         internal_data_in,
  output logic                         busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_REQ - 1);

  tx_sched_state_t      state_r;
  logic [IW-1:0]        ptr_r;
  logic [IW-1:0]        idx_r;
  logic [RW-1:0]        retry_cnt_r;
  logic [TW-1:0]        timer_r;
  logic [NUM_REQ-1:0]   arb_gnt_s;
  logic [IW-1:0]        arb_idx_s;
  logic [PAYLOAD_W-1:0] sel_payload_s;
  logic [IW-1:0]        ptr_next_s;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr_r),
    .gnt (arb_gnt_s),
    .idx (arb_idx_s)
  );

  // One-hot AND-OR mux of the arbitration winner's payload slice.
  always_comb begin
    sel_payload_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_payload_s = sel_payload_s |
                      ({PAYLOAD_W{arb_gnt_s[i]}} & payload[i*PAYLOAD_W +: PAYLOAD_W]);
    end
  end

  // Pointer moves just past the source that finished or was dropped.
  always_comb begin
    if (idx_r == IDX_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = idx_r + IW'(1);
    end
  end

  // Scheduler FSM; done/err mirror the still-held grant so they name the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      ptr_r            <= '0;
      idx_r            <= '0;
      retry_cnt_r      <= '0;
      timer_r          <= '0;
      grant            <= '0;
      done             <= '0;
      err              <= '0;
      shift_out        <= 1'b0;
      busy             <= 1'b0;
      internal_data_in <= '0;
    end else begin
      done      <= '0;
      err       <= '0;
      shift_out <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!dir && (|req)) begin
            grant            <= arb_gnt_s;
            idx_r            <= arb_idx_s;
            internal_data_in <= sel_payload_s;
            busy             <= 1'b1;
            state_r          <= LOAD;
          end
        end
        LOAD: begin
          // shift_out is registered, so the dir veto is taken one cycle early.
          shift_out <= !dir;
          state_r   <= START;
        end
        START: begin
          timer_r <= '0;
          if (dir) begin
            retry_cnt_r <= retry_cnt_r + RW'(1);
            state_r     <= BACKOFF;
          end else begin
            state_r <= WAIT_STP;
          end
        end
        WAIT_STP: begin
          if (stp) begin
            done        <= grant;
            grant       <= '0;
            ptr_r       <= ptr_next_s;
            retry_cnt_r <= '0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else if (dir || (timer_r == TIMER_LAST)) begin
            retry_cnt_r <= retry_cnt_r + RW'(1);
            state_r     <= BACKOFF;
          end else begin
            timer_r <= (timer_r == TIMER_LAST) ? timer_r : timer_r + TW'(1);
          end
        end
        BACKOFF: begin
          if (retry_cnt_r > RETRY_MAX) begin
            err         <= grant;
            grant       <= '0;
            ptr_r       <= ptr_next_s;
            retry_cnt_r <= '0;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else if (!dir) begin
            shift_out <= 1'b1;
            state_r   <= START;
          end
        end
        default: begin
          grant   <= '0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler: a vector table for arbitration order and
// handshake timing, plus sequences for reset, dir backoff and timeout retries.
module tb_usb_tx_scheduler;

  localparam int PW = 528;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic          dir;
  logic          stp;
  logic [PW-1:0] p0;
  logic [PW-1:0] p1;
  logic [PW-1:0] exp0;
  logic [2*PW-1:0] payload;
  logic [1:0]    grant;
  logic [1:0]    done;
  logic [1:0]    err;
  logic          shift_out;
  logic [PW-1:0] internal_data_in;
  logic          busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] req;
    logic       dir;
    logic       stp;
    logic [7:0] exp;   // {grant, done, err, shift_out, busy}
  } vec_t;

  vec_t vecs [22];

  assign payload = {p1, p0};

  always #5 clk = ~clk;

  usb_tx_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .payload          (payload),
    .grant            (grant),
    .done             (done),
    .err              (err),
    .dir              (dir),
    .stp              (stp),
    .shift_out        (shift_out),
    .internal_data_in (internal_data_in),
    .busy             (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; dir = 1'b0; stp = 1'b0;
    p0 = {33{16'hAABB}};
    p1 = {66{8'h5C}};
    tick();
    rst = 1'b0;
  endtask

  int nshift;
  int np;
  int pt [8];
  int err_t;
  int cyc;
  logic [1:0] err_seen;
  logic [1:0] done_seen;

  initial begin
    // grant, done, err, shift_out, busy
    vecs[0]  = {2'b11, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[1]  = {2'b11, 1'b0, 1'b0, 8'b01_00_00_1_1};
    vecs[2]  = {2'b11, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[3]  = {2'b11, 1'b0, 1'b1, 8'b00_01_00_0_0};
    vecs[4]  = {2'b11, 1'b0, 1'b0, 8'b10_00_00_0_1};
    vecs[5]  = {2'b11, 1'b0, 1'b0, 8'b10_00_00_1_1};
    vecs[6]  = {2'b11, 1'b0, 1'b0, 8'b10_00_00_0_1};
    vecs[7]  = {2'b11, 1'b0, 1'b1, 8'b00_10_00_0_0};
    vecs[8]  = {2'b11, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[9]  = {2'b11, 1'b0, 1'b0, 8'b01_00_00_1_1};
    vecs[10] = {2'b11, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[11] = {2'b11, 1'b0, 1'b1, 8'b00_01_00_0_0};
    vecs[12] = {2'b11, 1'b0, 1'b0, 8'b10_00_00_0_1};
    vecs[13] = {2'b11, 1'b0, 1'b0, 8'b10_00_00_1_1};
    vecs[14] = {2'b11, 1'b0, 1'b0, 8'b10_00_00_0_1};
    vecs[15] = {2'b11, 1'b0, 1'b1, 8'b00_10_00_0_0};
    vecs[16] = {2'b00, 1'b0, 1'b0, 8'b00_00_00_0_0};
    // granted req dropped mid-transfer; stp and dir together -> completes
    vecs[17] = {2'b01, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[18] = {2'b00, 1'b0, 1'b0, 8'b01_00_00_1_1};
    vecs[19] = {2'b00, 1'b0, 1'b0, 8'b01_00_00_0_1};
    vecs[20] = {2'b00, 1'b1, 1'b1, 8'b00_01_00_0_0};
    vecs[21] = {2'b00, 1'b0, 1'b0, 8'b00_00_00_0_0};

    do_reset();
    chk("reset_outputs", 64'({grant, done, err, shift_out, busy}), 64'd0);
    chk("reset_data", 64'(internal_data_in == '0), 64'd1);

    for (int i = 0; i < 22; i++) begin
      req = vecs[i].req; dir = vecs[i].dir; stp = vecs[i].stp;
      tick();
      checks++;
      if ({grant, done, err, shift_out, busy} !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d actual g=%b d=%b e=%b s=%b b=%b expected=%b",
                 i, grant, done, err, shift_out, busy, vecs[i].exp);
      end
    end

    // Single transfer: latency, payload latch, done after 66 byte times.
    do_reset();
    exp0 = p0;
    req = 2'b01;
    tick();
    chk("t2_grant_n1", 64'(grant), 64'h1);
    chk("t2_shift_n1", 64'(shift_out), 64'h0);
    chk("t2_data", 64'(internal_data_in === exp0), 64'd1);
    p0 = ~p0;
    tick();
    chk("t2_shift_n2", 64'(shift_out), 64'h1);
    tick();
    chk("t2_shift_pulse", 64'(shift_out), 64'h0);
    repeat (66) tick();
    chk("t2_wait", 64'({grant, done, shift_out}), 64'b01_00_0);
    stp = 1'b1;
    tick();
    chk("t2_done", 64'({grant, done, busy}), 64'b00_01_0);
    stp = 1'b0; req = 2'b00;
    tick();
    chk("t2_done_pulse", 64'(done), 64'h0);
    chk("t2_data_held", 64'(internal_data_in === exp0), 64'd1);

    // Reset in the middle of WAIT_STP.
    do_reset();
    req = 2'b01;
    repeat (5) tick();
    chk("t1_pre", 64'({grant, busy}), 64'b01_1);
    rst = 1'b1; req = 2'b00;
    tick();
    chk("t1_rst_outs", 64'({grant, done, err, shift_out, busy}), 64'd0);
    chk("t1_rst_data", 64'(internal_data_in == '0), 64'd1);
    rst = 1'b0;
    tick();
    chk("t1_no_done", 64'({done, err, busy}), 64'd0);

    // dir held in IDLE blocks grant; dir mid-WAIT_STP forces a retry.
    do_reset();
    exp0 = p0;
    dir = 1'b1; req = 2'b01;
    repeat (3) tick();
    chk("t4_blocked", 64'({grant, busy}), 64'd0);
    dir = 1'b0;
    tick();
    chk("t4_grant", 64'(grant), 64'h1);
    tick();
    chk("t5_shift1", 64'(shift_out), 64'h1);
    repeat (10) tick();
    dir = 1'b1;
    tick();
    chk("t5_backoff", 64'({grant, shift_out, busy}), 64'b01_0_1);
    p0 = ~p0;
    nshift = 0;
    repeat (19) begin
      tick();
      if (shift_out) nshift++;
    end
    chk("t5_no_shift", 64'(nshift), 64'd0);
    chk("t5_grant_held", 64'(grant), 64'h1);
    dir = 1'b0;
    tick();
    chk("t5_reshift", 64'(shift_out), 64'h1);
    chk("t5_same_data", 64'(internal_data_in === exp0), 64'd1);
    tick();
    stp = 1'b1;
    tick();
    chk("t5_done", 64'({done, err}), 64'b01_00);
    stp = 1'b0; req = 2'b00;
    tick();
    chk("t5_done_once", 64'({done, err}), 64'd0);

    // No stp ever: four attempts spaced by the timeout, then err.
    do_reset();
    req = 2'b11;
    np = 0; err_t = -1; err_seen = 2'b00; done_seen = 2'b00;
    for (int c = 1; c <= 12000 && err_t < 0; c++) begin
      tick();
      if (shift_out && np < 8) begin
        pt[np] = c;
        np++;
      end
      done_seen = done_seen | done;
      if (err != 2'b00) begin
        err_t = c;
        err_seen = err;
        chk("t6_grant_at_err", 64'(grant), 64'h0);
      end
    end
    chk("t6_err_seen", 64'(err_seen), 64'h1);
    chk("t6_no_done", 64'(done_seen), 64'h0);
    chk("t6_pulses", 64'(np), 64'd4);
    chk("t6_first", 64'(pt[0]), 64'd2);
    for (int k = 1; k < 4; k++) begin
      chk("t6_spacing", 64'(pt[k] - pt[k-1]), 64'd2050);
    end
    chk("t6_err_gap", 64'(err_t - pt[3]), 64'd2050);
    tick();
    chk("t6_err_pulse", 64'(err), 64'h0);
    chk("t6_next_src", 64'(grant), 64'h2);
    req = 2'b00;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
